// File: rtl/mmio_timer_pkg.sv
// ---------------------------------------------------------------------------
// mmio_timer_pkg
// Shared definitions for the memory-mapped timer: register indices within the
// 32-byte window, CTRL/STATUS bit positions, field widths and a helper that
// turns a register index into its byte offset.
// ---------------------------------------------------------------------------
package mmio_timer_pkg;

   localparam int REG_COUNT = 8;

   // Register indices (addr[4:2])
   localparam logic [2:0] IDX_CTRL     = 3'd0;
   localparam logic [2:0] IDX_PRESCALE = 3'd1;
   localparam logic [2:0] IDX_COUNT    = 3'd2;
   localparam logic [2:0] IDX_COMPARE  = 3'd3;
   localparam logic [2:0] IDX_STATUS   = 3'd4;
   localparam logic [2:0] IDX_TOHOST   = 3'd5;
   localparam logic [2:0] IDX_CYCLE    = 3'd6;
   localparam logic [2:0] IDX_RSVD     = 3'd7;

   // CTRL bits
   localparam int CTRL_W           = 3;
   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;

   // STATUS bits
   localparam int STATUS_W  = 2;
   localparam int ST_MATCH  = 0;
   localparam int ST_OVF    = 1;

   // Byte offset of a register within the window.
   function automatic logic [31:0] reg_offset(input logic [2:0] idx);
      return {27'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// ---------------------------------------------------------------------------
// mmio_prescaler
// Divides the clock for the timer: while en=1 the internal counter walks
// 0..limit and tick is high for the one cycle in which it sits at limit,
// after which it returns to 0. limit=0 therefore ticks every cycle.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   en     - run enable; the counter holds while low
//   clr    - synchronous clear of the counter (software reconfiguration)
//   limit  - terminal count
//   tick   - one-cycle pulse at terminal count
// ---------------------------------------------------------------------------
module mmio_prescaler #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] limit,
   output logic         tick
);

   logic [W-1:0] r_cnt;

   // A clear in the same cycle does not suppress the tick: the timer update
   // that tick triggers must still compete with the register write.
   assign tick = en && (r_cnt == limit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_cnt == limit) r_cnt <= '0;
         else                r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// ---------------------------------------------------------------------------
// mmio_timer
// Memory-mapped timer sharing the core store bus with DMEM. Eight word
// registers at BASE_ADDR: CTRL, PRESCALE, COUNT, COMPARE, STATUS (W1C),
// TOHOST, CYCLE (read-only) and one reserved slot.
// Ports:
//   clk     - clock, all state changes on its rising edge
//   reset   - asynchronous active-high reset
//   w_en    - store strobe
//   addr    - byte address (only full-word accesses are meaningful)
//   w_data  - store data
//   r_data  - combinational load data, 0 on a miss or reserved slot
//   irq     - CTRL.IRQ_EN & STATUS.MATCH
//   done    - sticky flag, set after a nonzero TOHOST write
// ---------------------------------------------------------------------------
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int          PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_en,
   input  logic [31:0] addr,
   input  logic [31:0] w_data,
   output logic [31:0] r_data,
   output logic        irq,
   output logic        done
);

   logic [CTRL_W-1:0]     r_ctrl;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [31:0]           r_count;
   logic [31:0]           r_compare;
   logic [STATUS_W-1:0]   r_status;
   logic [31:0]           r_tohost;
   logic [31:0]           r_cycle;
   logic                  r_done;

   logic                  w_hit;
   logic [2:0]            w_idx;
   logic                  w_wr;
   logic                  w_wr_ctrl;
   logic                  w_wr_prescale;
   logic                  w_wr_count;
   logic                  w_wr_status;
   logic                  w_tick;
   logic                  w_match;
   logic [CTRL_W-1:0]     w_ctrl_nxt;
   logic [STATUS_W-1:0]   w_status_nxt;
   logic [31:0]           w_count_nxt;
   logic                  w_unused;

   assign w_hit    = (addr[31:5] == BASE_ADDR[31:5]);
   assign w_idx    = addr[4:2];
   assign w_unused = ^addr[1:0];

   assign w_wr          = w_en && w_hit;
   assign w_wr_ctrl     = w_wr && (w_idx == IDX_CTRL);
   assign w_wr_prescale = w_wr && (w_idx == IDX_PRESCALE);
   assign w_wr_count    = w_wr && (w_idx == IDX_COUNT);
   assign w_wr_status   = w_wr && (w_idx == IDX_STATUS);

   mmio_prescaler #(.W(PRESCALE_W)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (r_ctrl[CTRL_EN]),
      .clr   (w_wr_ctrl || w_wr_prescale),
      .limit (r_prescale),
      .tick  (w_tick)
   );

   assign w_match = (r_count == r_compare);

   // Update order encodes the priorities: software writes first, then the
   // hardware tick effects override MATCH/OVF clears and the EN bit, and a
   // software COUNT write finally overrides any tick update of COUNT.
   always_comb begin
      w_ctrl_nxt   = r_ctrl;
      w_status_nxt = r_status;
      w_count_nxt  = r_count;
      if (w_wr_ctrl)   w_ctrl_nxt   = w_data[CTRL_W-1:0];
      if (w_wr_status) w_status_nxt = r_status & ~w_data[STATUS_W-1:0];
      if (w_tick) begin
         if (w_match) begin
            w_status_nxt[ST_MATCH] = 1'b1;
            if (r_ctrl[CTRL_AUTO_RELOAD]) w_count_nxt = 32'd0;
            else                          w_ctrl_nxt[CTRL_EN] = 1'b0;
         end else begin
            w_count_nxt = r_count + 32'd1;
            if (r_count == 32'hFFFF_FFFF) w_status_nxt[ST_OVF] = 1'b1;
         end
      end
      if (w_wr_count) w_count_nxt = w_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl     <= '0;
         r_prescale <= '0;
         r_count    <= '0;
         r_compare  <= '0;
         r_status   <= '0;
         r_tohost   <= '0;
         r_cycle    <= '0;
         r_done     <= 1'b0;
      end else begin
         r_ctrl   <= w_ctrl_nxt;
         r_status <= w_status_nxt;
         r_count  <= w_count_nxt;
         r_cycle  <= r_cycle + 32'd1;
         if (w_wr_prescale) r_prescale <= w_data[PRESCALE_W-1:0];
         if (w_wr && (w_idx == IDX_COMPARE)) r_compare <= w_data;
         if (w_wr && (w_idx == IDX_TOHOST)) begin
            r_tohost <= w_data;
            if (w_data != 32'd0) r_done <= 1'b1;
         end
      end
   end

   always_comb begin
      r_data = 32'd0;
      if (w_hit) begin
         case (w_idx)
            IDX_CTRL:     r_data = {{(32-CTRL_W){1'b0}}, r_ctrl};
            IDX_PRESCALE: r_data = 32'(r_prescale);
            IDX_COUNT:    r_data = r_count;
            IDX_COMPARE:  r_data = r_compare;
            IDX_STATUS:   r_data = {{(32-STATUS_W){1'b0}}, r_status};
            IDX_TOHOST:   r_data = r_tohost;
            IDX_CYCLE:    r_data = r_cycle;
            default:      r_data = 32'd0;
         endcase
      end
   end

   assign irq  = r_ctrl[CTRL_IRQ_EN] & r_status[ST_MATCH];
   assign done = r_done;

endmodule

// File: tb/tb_mmio_timer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mmio_timer
// Directed bench for mmio_timer. Register writes are driven on the falling
// edge and take effect on the following rising edge; reads set addr and
// sample r_data 1 ns later. Expected values go into exp_q when a check is
// issued and are popped against the DUT output.
// ---------------------------------------------------------------------------
module tb_mmio_timer;
   import mmio_timer_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_en;
   logic [31:0] addr;
   logic [31:0] w_data;
   logic [31:0] r_data;
   logic        irq;
   logic        done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] cyc_model;

   mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .w_en   (w_en),
      .addr   (addr),
      .w_data (w_data),
      .r_data (r_data),
      .irq    (irq),
      .done   (done)
   );

   // ---------------- clock / reset ----------------
   always #50 clk = ~clk;

   // Reference free-running cycle counter
   always @(posedge clk or posedge reset) begin
      if (reset) cyc_model <= 32'd0;
      else       cyc_model <= cyc_model + 32'd1;
   end

   // ---------------- driver tasks ----------------
   task automatic wr_raw(input logic [31:0] a, input logic [31:0] d);
      w_en   = 1'b1;
      addr   = a;
      w_data = d;
      @(negedge clk);
      w_en   = 1'b0;
      addr   = BASE + 32'h20;
      w_data = 32'd0;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d);
      wr_raw(BASE + reg_offset(idx), d);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- scoreboard ----------------
   task automatic compare(input string tag, input logic [31:0] got);
      logic [31:0] exp;
      exp = exp_q.pop_front();
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_raw(input string tag, input logic [31:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      addr = a;
      #1;
      compare(tag, r_data);
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [31:0] exp);
      chk_raw(tag, BASE + reg_offset(idx), exp);
   endtask

   task automatic chk_outs(input string tag, input logic e_irq, input logic e_done);
      exp_q.push_back({30'd0, e_irq, e_done});
      #1;
      compare(tag, {30'd0, irq, done});
   endtask

   task automatic chk_all_zero(input string tag);
      chk_reg({tag, "_ctrl"},     IDX_CTRL,     32'd0);
      chk_reg({tag, "_prescale"}, IDX_PRESCALE, 32'd0);
      chk_reg({tag, "_count"},    IDX_COUNT,    32'd0);
      chk_reg({tag, "_compare"},  IDX_COMPARE,  32'd0);
      chk_reg({tag, "_status"},   IDX_STATUS,   32'd0);
      chk_reg({tag, "_tohost"},   IDX_TOHOST,   32'd0);
      chk_reg({tag, "_cycle"},    IDX_CYCLE,    32'd0);
      chk_outs({tag, "_outs"}, 1'b0, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset  = 1'b1;
      w_en   = 1'b0;
      addr   = 32'd0;
      w_data = 32'd0;
      cyc(2);
      chk_all_zero("rst");
      reset = 1'b0;
      chk_outs("rst_rel_outs", 1'b0, 1'b0);

      // Auto-reload, prescale 3: COUNT steps every 4 cycles
      wr(IDX_PRESCALE, 32'd3);
      wr(IDX_COMPARE,  32'd2);
      wr(IDX_CTRL,     32'd3);
      cyc(3);
      chk_reg("ar_count0", IDX_COUNT, 32'd0);
      cyc(1);
      chk_reg("ar_count1", IDX_COUNT, 32'd1);
      cyc(4);
      chk_reg("ar_count2", IDX_COUNT, 32'd2);
      chk_reg("ar_status0", IDX_STATUS, 32'd0);
      cyc(4);
      chk_reg("ar_reload", IDX_COUNT, 32'd0);
      chk_reg("ar_match", IDX_STATUS, 32'd1);
      chk_outs("ar_noirq", 1'b0, 1'b0);
      wr(IDX_CTRL, 32'd0);
      wr(IDX_STATUS, 32'd1);
      chk_reg("ar_w1c", IDX_STATUS, 32'd0);

      // One-shot with IRQ, prescale 0
      wr(IDX_PRESCALE, 32'd0);
      wr(IDX_COMPARE,  32'd5);
      wr(IDX_COUNT,    32'd0);
      wr(IDX_CTRL,     32'd5);
      cyc(5);
      chk_reg("os_count5", IDX_COUNT, 32'd5);
      chk_outs("os_irq_pre", 1'b0, 1'b0);
      cyc(1);
      chk_outs("os_irq", 1'b1, 1'b0);
      chk_reg("os_en_clr", IDX_CTRL, 32'd4);
      chk_reg("os_status", IDX_STATUS, 32'd1);
      cyc(3);
      chk_reg("os_hold", IDX_COUNT, 32'd5);
      wr(IDX_STATUS, 32'd1);
      chk_outs("os_irq_clr", 1'b0, 1'b0);
      wr(IDX_CTRL, 32'd0);

      // Wrap sets OVF, W1C clears it
      wr(IDX_COUNT,    32'hFFFF_FFFF);
      wr(IDX_COMPARE,  32'd7);
      wr(IDX_PRESCALE, 32'd0);
      wr(IDX_CTRL,     32'd1);
      cyc(1);
      chk_reg("wrap_count", IDX_COUNT, 32'd0);
      chk_reg("wrap_ovf", IDX_STATUS, 32'd2);
      wr(IDX_STATUS, 32'd2);
      chk_reg("wrap_w1c", IDX_STATUS, 32'd0);
      wr(IDX_CTRL, 32'd0);
      cyc(3);
      chk_reg("wrap_stop_hold", IDX_COUNT, 32'd2);

      // Software COUNT write beats a same-cycle tick
      wr(IDX_COMPARE, 32'd1000);
      wr(IDX_COUNT,   32'd0);
      wr(IDX_CTRL,    32'd1);
      wr(IDX_COUNT,   32'd100);
      chk_reg("sw_count_prio", IDX_COUNT, 32'd100);
      wr(IDX_CTRL, 32'd0);
      cyc(2);
      chk_reg("sw_count_next", IDX_COUNT, 32'd101);

      // MATCH set beats a same-cycle W1C
      wr(IDX_COMPARE, 32'd0);
      wr(IDX_COUNT,   32'd0);
      wr(IDX_CTRL,    32'd3);
      wr(IDX_STATUS,  32'd1);
      chk_reg("match_vs_w1c", IDX_STATUS, 32'd1);
      chk_reg("match_reload", IDX_COUNT, 32'd0);
      wr(IDX_CTRL,   32'd0);
      wr(IDX_STATUS, 32'd1);
      chk_reg("match_cleared", IDX_STATUS, 32'd0);

      // One-shot EN clear beats a same-cycle CTRL write of EN
      wr(IDX_CTRL, 32'd1);
      wr(IDX_CTRL, 32'd1);
      chk_reg("en_clr_prio", IDX_CTRL, 32'd0);
      chk_reg("en_clr_status", IDX_STATUS, 32'd1);
      wr(IDX_STATUS, 32'd1);

      // Decode: miss writes/reads, masked fields, read-only and reserved slots
      wr_raw(BASE + 32'h108, 32'h55);
      chk_reg("miss_wr", IDX_COUNT, 32'd0);
      chk_raw("miss_rd", BASE + 32'h20, 32'd0);
      wr(IDX_PRESCALE, 32'hFFFF_1234);
      chk_reg("prescale_mask", IDX_PRESCALE, 32'h0000_1234);
      wr(IDX_CTRL, 32'hFFFF_FFF8);
      chk_reg("ctrl_mask", IDX_CTRL, 32'd0);
      wr(IDX_RSVD, 32'hDEAD_BEEF);
      chk_reg("rsvd_rd", IDX_RSVD, 32'd0);
      wr(IDX_CYCLE, 32'd0);
      chk_reg("cycle_ro", IDX_CYCLE, cyc_model);

      // TOHOST / done
      chk_outs("done_pre", 1'b0, 1'b0);
      wr(IDX_TOHOST, 32'd1);
      chk_outs("done_set", 1'b0, 1'b1);
      chk_reg("tohost1", IDX_TOHOST, 32'd1);
      wr(IDX_TOHOST, 32'd0);
      chk_outs("done_sticky", 1'b0, 1'b1);
      chk_reg("tohost0", IDX_TOHOST, 32'd0);

      // Reset mid-count
      wr(IDX_PRESCALE, 32'd5);
      wr(IDX_COMPARE,  32'd100);
      wr(IDX_COUNT,    32'd9);
      wr(IDX_CTRL,     32'd5);
      cyc(2);
      chk_reg("mid_count9", IDX_COUNT, 32'd9);
      reset = 1'b1;
      chk_all_zero("mid_rst");
      cyc(1);
      reset = 1'b0;
      cyc(10);
      chk_reg("post_rst_count", IDX_COUNT, 32'd0);
      chk_reg("post_rst_ctrl", IDX_CTRL, 32'd0);
      chk_reg("post_rst_cycle", IDX_CYCLE, cyc_model);
      chk_outs("post_rst_outs", 1'b0, 1'b0);
      wr(IDX_COMPARE, 32'd100);
      wr(IDX_CTRL,    32'd1);
      cyc(3);
      chk_reg("post_rst_run", IDX_COUNT, 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, meaning the 32-byte-aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE_W, default 16, meaning the prescaler width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port w_en  input  1  store strobe from the core memory stage.
REQ-006 SHALL have port addr  input  32  byte address from the core memory stage.
REQ-007 SHALL have port w_data  input  32  store data.
REQ-008 SHALL have port r_data  output  32  combinational load data.
REQ-009 SHALL have port irq  output  1  equals CTRL.IRQ_EN AND STATUS.MATCH.
REQ-010 SHALL have port done  output  1  set once TOHOST is written with a nonzero value.

Function
REQ-011 SHALL decode a hit when addr[31:5] == BASE_ADDR[31:5]; register index = addr[4:2]; addr[1:0] ignored; full-word access only.
REQ-012 SHALL implement the register map:
- 0x00 CTRL rw: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
- 0x04 PRESCALE rw: [PRESCALE_W-1:0].
- 0x08 COUNT rw.
- 0x0C COMPARE rw.
- 0x10 STATUS r/W1C: bit0 MATCH, bit1 OVF.
- 0x14 TOHOST rw.
- 0x18 CYCLE ro: free-running cycle count.
- 0x1C reserved, reads 0.
REQ-013 SHALL drive r_data combinationally from addr with zero latency; a miss or reserved index returns 32'h0.
REQ-014 SHALL apply writes on the clk edge where w_en=1 and the address hits; writes to CYCLE or reserved are ignored.
REQ-015 SHALL run a prescaler counter only while EN=1: it counts 0..PRESCALE, emits a one-cycle tick on reaching PRESCALE, and then returns to 0; PRESCALE=0 gives a tick every cycle.
REQ-016 SHALL hold the prescaler counter when EN=0; writing CTRL or PRESCALE clears it to 0.
REQ-017 SHALL, on a tick with COUNT==COMPARE, set MATCH and:
- if AUTO_RELOAD=1, load COUNT with 0;
- otherwise hold COUNT and clear EN (one-shot stop).
REQ-018 SHALL, on a tick with COUNT!=COMPARE, increment COUNT modulo 2^32; the wrap from 32'hFFFF_FFFF to 0 sets OVF.
REQ-019 SHALL give a software COUNT write priority over a same-cycle tick update; the written value is used with no increment.
REQ-020 SHALL give a hardware set of MATCH/OVF priority over a same-cycle W1C clear of the same bit.
REQ-021 SHALL give the hardware EN clear of REQ-017 priority over a same-cycle CTRL write setting EN.
REQ-022 SHALL increment CYCLE every cycle regardless of EN, wrapping silently.
REQ-023 SHALL latch w_data into TOHOST on write; done rises the cycle after a nonzero write and stays 1 until reset; a later write of 0 does not clear done.

Reset
REQ-024 SHALL asynchronously clear on reset=1: CTRL, PRESCALE, COUNT, COMPARE, STATUS, TOHOST, CYCLE and the prescaler counter to 0.
REQ-025 SHALL hold irq=0 and done=0 during and immediately after reset; r_data then reflects reset register values.
REQ-026 SHALL, on reset mid-count, abandon any pending tick; counting resumes only after software sets EN again.

Structure
REQ-027 SHALL place the register offsets, CTRL/STATUS bit positions and the register count in a shared package, mmio_timer_pkg.
REQ-028 SHALL implement the prescaler as one sub-module, mmio_prescaler (inputs en, clr, limit; output tick).
REQ-029 SHALL be instantiable alongside DMEM, sharing clk, w_en, addr and w_data; the integrator muxes r_data on address hit.

Verification
REQ-030 Write PRESCALE=3, COMPARE=2, CTRL=3 -> tick every 4 cycles; COUNT goes 0,1,2; MATCH sets on the 3rd tick; COUNT returns to 0.
REQ-031 Write PRESCALE=0, COMPARE=5, CTRL=5 (one-shot, IRQ_EN) -> irq=1 at COUNT=5; EN reads 0; COUNT holds at 5.
REQ-032 Write COUNT=32'hFFFF_FFFF, COMPARE=7, CTRL=1, PRESCALE=0 -> next tick gives COUNT=0 and OVF=1; a W1C of 2 then clears OVF.
REQ-033 Same-cycle COUNT write of 100 and a tick -> COUNT reads 100; W1C of MATCH on the cycle MATCH sets -> MATCH stays 1.
REQ-034 Write TOHOST=1 -> done=1 the next cycle; a later write of 0 leaves done=1; read of 0x1C returns 0.
REQ-035 Assert reset mid-count with COUNT=9 -> all registers read 0, irq=0, done=0; no tick after reset release until EN is set.
